// File: rtl/reg_scoreboard.sv
// reg_scoreboard: hazard scoreboard and forwarding controller.
// Tracks every instruction between issue and write-back in a DEPTH-stage shift pipeline. For
// each enabled source it either selects the youngest matching stage as the forwarding source,
// or stalls decode while that result is not yet produced.
//
// Ports:
//   clk1, rst_n           pipeline clock, asynchronous active-low reset
//   iss_*                 decode-side instruction (sources, destinations, latency)
//   flush                 discard all in-flight entries, refuse issue this cycle
//   stall, iss_ok         decode hold / entry accepted (combinational)
//   fwd_sel, fwd_hi       per-source forwarding stage and high-word select (combinational)
//   wb_*                  write-back of the stage-DEPTH entry (combinational)
//   pending               registered per-register "result outstanding" mask
//   stall_count           registered saturating count of stalled cycles
module reg_scoreboard #(
    parameter int unsigned NREGS  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned DEPTH  = 3,
    parameter int unsigned NSRC   = 4,
    parameter int unsigned STALLW = 16,
    parameter int unsigned LW     = 2,
    localparam int unsigned FW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 iss_valid,
    input  logic [NSRC*AW-1:0]   iss_src,
    input  logic [NSRC-1:0]      iss_src_en,
    input  logic [AW-1:0]        iss_dst0,
    input  logic                 iss_dst0_en,
    input  logic [AW-1:0]        iss_dst1,
    input  logic                 iss_dst1_en,
    input  logic [LW-1:0]        iss_lat,
    input  logic                 flush,
    output logic                 stall,
    output logic                 iss_ok,
    output logic [NSRC*FW-1:0]   fwd_sel,
    output logic [NSRC-1:0]      fwd_hi,
    output logic                 wb_valid,
    output logic [AW-1:0]        wb_dst0,
    output logic                 wb_dst0_en,
    output logic [AW-1:0]        wb_dst1,
    output logic                 wb_dst1_en,
    output logic [NREGS-1:0]     pending,
    output logic [STALLW-1:0]    stall_count
);

    // Index k holds the entry in stage k+1.
    logic [DEPTH-1:0]          vld_q, vld_d;
    logic [DEPTH-1:0]          e0_q, e0_d;
    logic [DEPTH-1:0]          e1_q, e1_d;
    logic [DEPTH-1:0][AW-1:0]  d0_q, d0_d;
    logic [DEPTH-1:0][AW-1:0]  d1_q, d1_d;
    logic [DEPTH-1:0][FW-1:0]  lat_q, lat_d;
    logic [NREGS-1:0]          pending_d;
    logic [FW-1:0]             lat_c;
    logic                      stall_raw;
    logic                      wb_dup;

    always_comb begin
        if (iss_lat == '0) begin
            lat_c = FW'(1);
        end else if (32'(iss_lat) > DEPTH) begin
            lat_c = FW'(DEPTH);
        end else begin
            lat_c = FW'(iss_lat);
        end
    end

    // Per-source scan, youngest stage first; the first match decides forward or stall.
    always_comb begin : scan
        logic [AW-1:0] src;
        logic          found;
        logic          m0;
        logic          m1;
        stall_raw = 1'b0;
        fwd_sel   = '0;
        fwd_hi    = '0;
        src       = '0;
        found     = 1'b0;
        m0        = 1'b0;
        m1        = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            src   = iss_src[s*AW +: AW];
            found = 1'b0;
            if (iss_src_en[s]) begin
                for (int k = 0; k < DEPTH; k++) begin
                    m0 = vld_q[k] & e0_q[k] & (d0_q[k] == src);
                    m1 = vld_q[k] & e1_q[k] & (d1_q[k] == src);
                    if (!found && (m0 || m1)) begin
                        found = 1'b1;
                        if (FW'(k + 1) >= lat_q[k]) begin
                            fwd_sel[s*FW +: FW] = FW'(k + 1);
                            fwd_hi[s]           = m1;
                        end else begin
                            stall_raw = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign stall  = iss_valid & stall_raw;
    // Held low during reset so nothing reads as accepted while state is being cleared.
    assign iss_ok = rst_n & iss_valid & ~stall & ~flush;

    // A dual-destination entry naming the same register twice writes once, via dst1.
    assign wb_dup     = e0_q[DEPTH-1] & e1_q[DEPTH-1] & (d0_q[DEPTH-1] == d1_q[DEPTH-1]);
    assign wb_valid   = vld_q[DEPTH-1];
    assign wb_dst0_en = vld_q[DEPTH-1] & e0_q[DEPTH-1] & ~wb_dup;
    assign wb_dst1_en = vld_q[DEPTH-1] & e1_q[DEPTH-1];
    assign wb_dst0    = wb_dst0_en ? d0_q[DEPTH-1] : '0;
    assign wb_dst1    = wb_dst1_en ? d1_q[DEPTH-1] : '0;

    always_comb begin
        vld_d = '0;
        e0_d  = '0;
        e1_d  = '0;
        d0_d  = '0;
        d1_d  = '0;
        lat_d = '0;
        if (!flush) begin
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
                e0_d[k]  = e0_q[k-1];
                e1_d[k]  = e1_q[k-1];
                d0_d[k]  = d0_q[k-1];
                d1_d[k]  = d1_q[k-1];
                lat_d[k] = lat_q[k-1];
            end
            if (iss_ok) begin
                vld_d[0] = 1'b1;
                e0_d[0]  = iss_dst0_en;
                e1_d[0]  = iss_dst1_en;
                d0_d[0]  = iss_dst0;
                d1_d[0]  = iss_dst1;
                lat_d[0] = lat_c;
            end
        end
    end

    // pending is registered, so it is built from the entries present next cycle.
    always_comb begin
        pending_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_d[k] && e0_d[k]) pending_d[d0_d[k]] = 1'b1;
            if (vld_d[k] && e1_d[k]) pending_d[d1_d[k]] = 1'b1;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= '0;
            e0_q        <= '0;
            e1_q        <= '0;
            d0_q        <= '0;
            d1_q        <= '0;
            lat_q       <= '0;
            pending     <= '0;
            stall_count <= '0;
        end else begin
            vld_q   <= vld_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            lat_q   <= lat_d;
            pending <= pending_d;
            if (stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Parametrised hazard scoreboard and forwarding controller for the processor pipeline. It tracks every in-flight instruction between decode and register write-back, together with each one's destination registers and result latency. It stalls decode only when a source depends on a result that is not yet produced; otherwise it selects the forwarding stage. It replaces the single-entry, halt-until-writeback hazard check in the current top level and adds support for multi-cycle multiplies, dual-destination long multiplies, flush and a stall counter.

## Interface
- NREGS, 16, architectural register count
- AW, 4, register address width (log2 NREGS)
- DEPTH, 3, in-flight stages from issue to write-back (≥2)
- NSRC, 4, source operands checked per issue (Rn, Rm, Rs, Ra)
- STALLW, 16, stall counter width
- FW (derived), clog2(DEPTH+1), forward-select width

Ports:
- clk1  in  1  pipeline clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- iss_valid  in  1  decode presents an instruction
- iss_src  in  NSRC*AW  source register numbers, source i at [i*AW +: AW]
- iss_src_en  in  NSRC  source i is read
- iss_dst0 / iss_dst0_en  in  AW / 1  primary destination (Rd, RdLo)
- iss_dst1 / iss_dst1_en  in  AW / 1  secondary destination (RdHi)
- iss_lat  in  2+  cycles until result valid: ALU 1, MUL/MLA 2, UMULL/SMULL 2
- flush  in  1  discard all in-flight entries
- stall  out  1  combinational; decode must hold
- iss_ok  out  1  iss_valid & ~stall & ~flush; the entry is accepted
- fwd_sel  out  NSRC*FW  per source: 0 = register file, k = stage-k result bus
- fwd_hi  out  NSRC  per source: take the high word (dst1 result) of the selected stage
- wb_valid, wb_dst0, wb_dst0_en, wb_dst1, wb_dst1_en  out  write-back of the stage-DEPTH entry
- pending  out  NREGS  bit r set while any entry targets r
- stall_count  out  STALLW  saturating count of stalled cycles

## Operation
- Shift pipeline of DEPTH entries {valid, dst0, dst0_en, dst1, dst1_en, lat}. Every cycle, each entry moves from stage k to k+1. The stage-DEPTH entry retires. Stage 1 loads the issue if iss_ok, otherwise a bubble. No back-pressure after issue.
- iss_lat is clamped: 0 becomes 1, and values above DEPTH become DEPTH.
- Entry in stage k is ready when k ≥ lat.
- For each enabled source, scan valid entries, youngest (lowest k) first. The first entry whose dst0 or dst1 (with its enable set) matches is used:
  - ready: fwd_sel = k, fwd_hi = 1 if the match is on dst1
  - not ready: stall = 1
  - no match: fwd_sel = 0, fwd_hi = 0
- If dst0 == dst1 within one entry, dst1 wins, giving fwd_hi = 1 and a single write on wb_dst1.
- Disabled sources produce fwd_sel = 0 and never stall.
- stall is qualified by iss_valid; it is 0 when iss_valid is 0.
- An issuing instruction is never compared against its own destinations.
- flush: all entries are cleared at the edge. Issue is refused that cycle. The stage-DEPTH entry present during the flush cycle still reports wb_valid, because write-back is already committed.
- pending is the OR over valid entries of the enabled destinations.
- stall_count increments on each cycle with stall = 1 and saturates at all-ones.

## Timing
- Reset (async, immediate): all entries invalid. stall = 0, iss_ok = 0, fwd_sel = 0, fwd_hi = 0, wb_valid = 0, wb_* = 0, pending = 0, stall_count = 0.
- Issue accepted at edge t: entry occupies stage 1 during cycle t+1 and stage DEPTH during cycle t+DEPTH, when wb_valid = 1. The register file is written at the end of that cycle.
- A dependent instruction issuing in cycle t+1 forwards from stage 1 if lat = 1. With lat = 2 it stalls exactly one cycle and then forwards from stage 2.
- stall, iss_ok, fwd_sel, fwd_hi and wb_* are combinational from current state and issue inputs. pending and stall_count are registered.
- Reset mid-operation drops every entry. No wb_valid is produced for dropped entries.

## Test plan
- ADD r0 (lat 1) issued at t0, AND reading r0 at t1 -> stall = 0, fwd_sel[Rn] = 1; wb_valid with wb_dst0 = 0 at t3 (DEPTH = 3).
- MUL r0 (lat 2) at t0, ADD reading r0 at t1 -> stall = 1 at t1, stall_count = 1; accepted at t2 with fwd_sel = 2.
- UMULL lo r3, hi r4 (lat 2) at t0, bubble, reader of r4 at t2 -> fwd_sel = 2, fwd_hi = 1; reader of r3 -> fwd_hi = 0; pending = 0x0018 in cycles t1–t3.
- Writers to r1 at t0 and t1 (both lat 1), reader of r1 at t2 -> fwd_sel = 1 (youngest), not 2.
- MUL r5 at t0, reader of r5 stalled at t1, flush at t1 -> iss_ok = 0 at t1, pending = 0 at t2, reader accepted at t2 with fwd_sel = 0.
- STALLW = 4, 20 consecutive stalled cycles -> stall_count = 15; rst_n low mid-run -> all outputs 0 immediately.
